// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory pipeline stage:
//   state_t          - FSM states of the stage (IDLE / MEM / HALTED)
//   TIMEOUT_DEFAULT  - default MEM-state wait limit for mem_ack
//   cnt_width()      - minimum counter width able to hold a given limit
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd15;

    // Bits needed to represent the value t itself (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned t);
        if (t < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(t + 32'd1);
        end
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Bundles every non-clock signal of the memory stage.
//   upstream  : in_valid, in_ready, alu_res, st_data, mem_rd, mem_wr,
//               halt_in, dst_in, wen_in
//   memory    : mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//   writeback : wb_valid, wb_data, wb_dst, wb_en
//   status    : halted, err
// Modports: slave  - the stage itself
//           master - the environment (execute stage, memory, writeback)
// -----------------------------------------------------------------------------
interface mem_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_res;
    logic [15:0] st_data;
    logic        mem_rd;
    logic        mem_wr;
    logic        halt_in;
    logic [2:0]  dst_in;
    logic        wen_in;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_dst;
    logic        wb_en;

    logic        halted;
    logic        err;

    modport slave (
        input  in_valid, alu_res, st_data, mem_rd, mem_wr, halt_in, dst_in, wen_in,
        input  mem_rdata, mem_ack,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output wb_valid, wb_data, wb_dst, wb_en,
        output halted, err
    );

    modport master (
        output in_valid, alu_res, st_data, mem_rd, mem_wr, halt_in, dst_in, wen_in,
        output mem_rdata, mem_ack,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  wb_valid, wb_data, wb_dst, wb_en,
        input  halted, err
    );

endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of a simple in-order pipeline. Non-memory results retire one
// cycle after acceptance; loads/stores issue a held request and wait up to
// TIMEOUT MEM cycles for mem_ack; misaligned accesses and timeouts raise a
// sticky err and halt; a halt instruction retires once and then halts.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mem_stage_if.slave (upstream, memory, writeback, status)
// Parameter:
//   TIMEOUT - maximum MEM-state cycles to wait for mem_ack
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);

    localparam int unsigned     CW        = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]   TIMEOUT_C = CW'(TIMEOUT);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           we_q, we_d;
    logic [2:0]     dst_q, dst_d;
    logic           wen_q, wen_d;
    logic           err_q, err_d;

    logic           wb_valid_q, wb_valid_d;
    logic [15:0]    wb_data_q, wb_data_d;
    logic [2:0]     wb_dst_q, wb_dst_d;
    logic           wb_en_q, wb_en_d;

    logic           accept_s;
    logic [CW-1:0]  cnt_inc_s;

    assign accept_s  = bus.in_valid & (state_q == IDLE);
    assign cnt_inc_s = cnt_q + {{(CW-1){1'b0}}, 1'b1};

    // Next-state, capture and writeback decision logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        dst_d      = dst_q;
        wen_d      = wen_q;
        err_d      = err_q;
        wb_valid_d = 1'b0;
        wb_data_d  = 16'h0000;
        wb_dst_d   = 3'd0;
        wb_en_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (bus.halt_in) begin
                        // Halt wins over any memory flag in the same word.
                        wb_valid_d = 1'b1;
                        wb_dst_d   = bus.dst_in;
                        state_d    = HALTED;
                    end else if (bus.mem_rd | bus.mem_wr) begin
                        if (bus.alu_res[0]) begin
                            // Odd address: never reaches memory.
                            err_d   = 1'b1;
                            state_d = HALTED;
                        end else begin
                            addr_d  = bus.alu_res;
                            wdata_d = bus.st_data;
                            we_d    = bus.mem_wr;
                            dst_d   = bus.dst_in;
                            wen_d   = bus.wen_in;
                            cnt_d   = {CW{1'b0}};
                            state_d = MEM;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.alu_res;
                        wb_dst_d   = bus.dst_in;
                        wb_en_d    = bus.wen_in;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MEM: begin
                if (bus.mem_ack) begin
                    // Ack beats the timeout even in the final wait cycle.
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_dst_d   = dst_q;
                    if (we_q) begin
                        wb_data_d = 16'h0000;
                        wb_en_d   = 1'b0;
                    end else begin
                        wb_data_d = bus.mem_rdata;
                        wb_en_d   = wen_q;
                    end
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    cnt_d   = cnt_inc_s;
                    err_d   = 1'b1;
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, timeout counter, captured request and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            we_q    <= 1'b0;
            dst_q   <= 3'd0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            dst_q   <= dst_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
        end
    end

    // Writeback output register; valid is a one-cycle pulse per retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= 16'h0000;
            wb_dst_q   <= 3'd0;
            wb_en_q    <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_dst_q   <= wb_dst_d;
            wb_en_q    <= wb_en_d;
        end
    end

    // Status and handshake outputs are decodes of the state register, so the
    // asynchronous reset removes mem_req without waiting for a clock edge.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.mem_req   = (state_q == MEM);
    assign bus.halted    = (state_q == HALTED);
    assign bus.err       = err_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_dst    = wb_dst_q;
    assign bus.wb_en     = wb_en_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. Each instruction's outcome is predicted
// from its class (ALU / load / store / misaligned / halt) and the chosen
// memory response delay; the bench plays the memory and compares every cycle.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int TO = 15;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time bound.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.alu_res   = 16'h0000;
        bus.st_data   = 16'h0000;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.halt_in   = 1'b0;
        bus.dst_in    = 3'd0;
        bus.wen_in    = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    // Everything at its reset value; checked with no clock edge involved.
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_mem_req"},  32'(bus.mem_req),  32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        chk({tag, "_wb_en"},    32'(bus.wb_en),    32'd0);
        chk({tag, "_halted"},   32'(bus.halted),   32'd0);
        chk({tag, "_err"},      32'(bus.err),      32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Stopped stage must ignore upstream and stay quiet.
    task automatic halted_probe(input bit exp_err);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.alu_res  = 16'($urandom);
            bus.mem_rd   = 1'($urandom_range(0, 1));
            bus.wen_in   = 1'b1;
            bus.mem_ack  = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("hlt_wb_valid", 32'(bus.wb_valid), 32'd0);
            chk("hlt_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hlt_mem_req",  32'(bus.mem_req),  32'd0);
            chk("hlt_halted",   32'(bus.halted),   32'd1);
            chk("hlt_err",      32'(bus.err),      32'(exp_err));
        end
        idle_inputs();
    endtask

    // Issue one instruction and check it to completion. ack_k: MEM cycle
    // (1-based) in which memory acknowledges; > TO means never.
    task automatic run_op(input bit halt, input bit rd, input bit wr,
                          input logic [15:0] alu, input logic [15:0] st,
                          input logic [2:0] dst, input bit wen,
                          input int ack_k, input logic [15:0] rdata,
                          output bit stopped);
        bit is_mem;
        bit done;
        stopped = 1'b0;
        is_mem  = rd | wr;
        @(negedge clk);
        chk("pre_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.halt_in   = halt;
        bus.mem_rd    = rd;
        bus.mem_wr    = wr;
        bus.alu_res   = alu;
        bus.st_data   = st;
        bus.dst_in    = dst;
        bus.wen_in    = wen;
        // Stray memory response while idle must not matter.
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        if (halt) begin
            chk("halt_wb_valid", 32'(bus.wb_valid), 32'd1);
            chk("halt_wb_en",    32'(bus.wb_en),    32'd0);
            chk("halt_mem_req",  32'(bus.mem_req),  32'd0);
            chk("halt_halted",   32'(bus.halted),   32'd1);
            halted_probe(1'b0);
            stopped = 1'b1;
        end else if (is_mem && alu[0]) begin
            chk("mis_mem_req",  32'(bus.mem_req),  32'd0);
            chk("mis_wb_valid", 32'(bus.wb_valid), 32'd0);
            chk("mis_err",      32'(bus.err),      32'd1);
            chk("mis_halted",   32'(bus.halted),   32'd1);
            halted_probe(1'b1);
            stopped = 1'b1;
        end else if (!is_mem) begin
            chk("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
            chk("alu_wb_data",  32'(bus.wb_data),  32'(alu));
            chk("alu_wb_dst",   32'(bus.wb_dst),   32'(dst));
            chk("alu_wb_en",    32'(bus.wb_en),    32'(wen));
            chk("alu_in_ready", 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            chk("alu_pulse_end", 32'(bus.wb_valid), 32'd0);
            chk("alu_en_low",    32'(bus.wb_en),    32'd0);
        end else begin
            done = 1'b0;
            for (int k = 1; k <= TO && !done; k++) begin
                chk("mem_req",      32'(bus.mem_req),   32'd1);
                chk("mem_in_ready", 32'(bus.in_ready),  32'd0);
                chk("mem_addr",     32'(bus.mem_addr),  32'(alu));
                chk("mem_we",       32'(bus.mem_we),    32'(wr));
                chk("mem_wdata",    32'(bus.mem_wdata), 32'(st));
                chk("mem_wb_valid", 32'(bus.wb_valid),  32'd0);
                // Upstream noise while not ready must be ignored.
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.alu_res  = 16'($urandom);
                bus.st_data  = 16'($urandom);
                bus.mem_wr   = 1'($urandom_range(0, 1));
                bus.halt_in  = 1'($urandom_range(0, 1));
                if (k == ack_k) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
                @(posedge clk);
                @(negedge clk);
                idle_inputs();
                bus.mem_rdata = 16'($urandom);
                if (k == ack_k) begin
                    done = 1'b1;
                    chk("ack_wb_valid", 32'(bus.wb_valid), 32'd1);
                    chk("ack_wb_data",  32'(bus.wb_data),  wr ? 32'd0 : 32'(rdata));
                    chk("ack_wb_en",    32'(bus.wb_en),    wr ? 32'd0 : 32'(wen));
                    chk("ack_wb_dst",   32'(bus.wb_dst),   32'(dst));
                    chk("ack_mem_req",  32'(bus.mem_req),  32'd0);
                    chk("ack_in_ready", 32'(bus.in_ready), 32'd1);
                    chk("ack_err",      32'(bus.err),      32'd0);
                    @(negedge clk);
                    chk("ack_pulse_end", 32'(bus.wb_valid), 32'd0);
                end else if (k == TO) begin
                    chk("to_err",      32'(bus.err),      32'd1);
                    chk("to_mem_req",  32'(bus.mem_req),  32'd0);
                    chk("to_halted",   32'(bus.halted),   32'd1);
                    chk("to_wb_valid", 32'(bus.wb_valid), 32'd0);
                    halted_probe(1'b1);
                    stopped = 1'b1;
                end
            end
        end
    endtask

    initial begin
        bit          st;
        logic [15:0] a;
        int          r;
        int          ak;
        bit          h, rd, wr;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk_reset_vals("por");
        do_reset();

        // ALU result writeback.
        run_op(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 3'd3, 1'b1, 0, 16'h0000, st);
        // Load, ack in third MEM cycle.
        run_op(1'b0, 1'b1, 1'b0, 16'h0040, 16'h5555, 3'd5, 1'b1, 3, 16'hBEEF, st);
        // Store, ack in second cycle.
        run_op(1'b0, 1'b0, 1'b1, 16'h0022, 16'hA5A5, 3'd2, 1'b1, 2, 16'h7777, st);
        // Misaligned store.
        run_op(1'b0, 1'b0, 1'b1, 16'h0041, 16'h1111, 3'd1, 1'b0, 1, 16'h0000, st);
        do_reset();
        // Store with no ack: timeout.
        run_op(1'b0, 1'b0, 1'b1, 16'h0010, 16'h2222, 3'd4, 1'b0, TO + 5, 16'h0000, st);
        do_reset();
        // Same store, ack in the final allowed cycle.
        run_op(1'b0, 1'b0, 1'b1, 16'h0010, 16'h2222, 3'd4, 1'b0, TO, 16'h0000, st);
        // Load acked in the final allowed cycle.
        run_op(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 3'd7, 1'b1, TO, 16'hC0DE, st);

        // Reset in the middle of a memory wait.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.alu_res  = 16'h0080;
        bus.dst_in   = 3'd6;
        bus.wen_in   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        chk("mid_mem_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req",  32'(bus.mem_req),  32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("late_ack_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("late_ack_in_ready", 32'(bus.in_ready), 32'd1);
        chk("late_ack_mem_req",  32'(bus.mem_req),  32'd0);
        idle_inputs();
        // Halt with memory flags also set: halt wins.
        run_op(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0000, 3'd2, 1'b1, 1, 16'h0000, st);
        do_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 11);
            h  = (r == 0);
            rd = 1'b0;
            wr = 1'b0;
            a  = 16'($urandom);
            if (r >= 1 && r <= 7) begin
                rd   = 1'($urandom_range(0, 1));
                wr   = ~rd;
                a[0] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                ak = $urandom_range(1, TO + 2);
            end else begin
                ak = $urandom_range(1, 4);
            end
            run_op(h, rd, wr, a, 16'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), ak, 16'($urandom), st);
            if (st) begin
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
